// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor, the hybrid adder and the ALU wrapper.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one difference bit produced per clock
// DONE  | one-cycle completion pulse; start here begins a new run
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bw_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bw_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds only the already-produced upper bits; the bit of the current edge is d_bit.
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic             brw;
  logic             a_msb;
  logic             b_msb;
  logic             d_bit;
  logic             bout_bit;
  logic             accept;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign r_next = {d_bit, r_sh};
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

  // FSM, bit counter, operand/result shift registers and borrow flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      brw   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (accept) begin
      state <= ST_RUN;
      count <= '0;
      a_sh  <= a;
      b_sh  <= b;
      brw   <= bw_in;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else begin
      case (state)
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_next[WIDTH-1:1];
          brw   <= bout_bit;
          count <= count + CNT_ONE;
          if (count == LAST_BIT) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result and flags load only on the last-bit edge and are held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      bw_out <= 1'b0;
      ovf    <= 1'b0;
    end else if ((state == ST_RUN) && (count == LAST_BIT)) begin
      diff   <= r_next;
      bw_out <= bout_bit;
      ovf    <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bw_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bw_out;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] last_diff = '0;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbi;
    logic [W-1:0] ed;
    logic         ebo;
    logic         eov;
  } vec_t;

  vec_t vecs [8];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bw_in  (bw_in),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .bw_out (bw_out),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure spacing between done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one operation, scramble inputs while busy, and wait for done.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbi);
    int busy_cnt;
    bit seen;
    bit both;
    @(negedge clk);
    a = va; b = vb; bw_in = vbi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bw_in = 1'($urandom_range(0, 1));
    busy_cnt = 0; seen = 0; both = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy && done) both = 1;
      if (busy) begin
        busy_cnt++;
        if (busy_cnt == 1) check("diff_held_mid_run", diff, last_diff);
      end
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    check("busy_cycles", busy_cnt, W);
    check("busy_done_overlap", both, 0);
  endtask

  initial begin
    int dones;
    int t1;
    int t2;
    bit seen;

    vecs[0] = '{8'h0D, 8'h91, 1'b1, 8'h7B, 1'b1, 1'b0};
    vecs[1] = '{8'd200, 8'd55, 1'b0, 8'h91, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'h01, 1'b1, 8'hFD, 1'b0, 1'b0};

    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bw_out", bw_out, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vbi);
      check($sformatf("vec%0d_diff", i), diff, vecs[i].ed);
      check($sformatf("vec%0d_bw_out", i), bw_out, vecs[i].ebo);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].eov);
      last_diff = vecs[i].ed;
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // Second start during RUN must be ignored.
    @(negedge clk);
    a = 8'd9; b = 8'd4; bw_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ign_start_dones", dones, 1);
    check("ign_start_diff", diff, 8'd5);
    check("ign_start_idle", busy, 0);
    last_diff = 8'd5;

    // Reset in the middle of a run.
    @(negedge clk);
    a = 8'h33; b = 8'h11; bw_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_diff", diff, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    last_diff = '0;
    run_op(8'h33, 8'h11, 1'b0);
    check("post_rst_diff", diff, 8'h22);
    check("post_rst_bw_out", bw_out, 0);
    last_diff = 8'h22;

    // Back-to-back: start held in the DONE cycle.
    @(negedge clk);
    a = 8'd50; b = 8'd20; bw_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("b2b_first_done", seen, 1);
    check("b2b_first_diff", diff, 8'h1E);
    t1 = cyc;
    a = 8'd10; b = 8'd30; bw_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_restart_busy", busy, 1);
    check("b2b_held_diff", diff, 8'h1E);
    seen = 0;
    t2 = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy && i == 4) check("b2b_held_mid", diff, 8'h1E);
      if (done) begin
        seen = 1;
        t2 = cyc;
      end
    end
    check("b2b_second_done", seen, 1);
    check("b2b_spacing", t2 - t1, 9);
    check("b2b_second_diff", diff, 8'hEC);
    check("b2b_second_bw_out", bw_out, 1);
    check("b2b_second_ovf", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
